i2c_slave_reg_bridge: RTL

- I2C target (responder) with 16-bit sub-address and 8-bit data. It is the counterpart of the camera/bridge I2C configuration masters.
- Used as a behavioural and synthesisable stand-in for the D8M sensor and the MIPI bridge register map, and as a debug port on the FPGA.
- Decodes START, STOP and repeated START, matches a 7-bit device address, and auto-increments the sub-address.
- Translates bus transfers into a simple single-cycle register bus.

---
 rtl/i2c_slave_pkg.sv | 28 ++
 rtl/i2c_line_filter.sv | 54 +++++
 rtl/i2c_slave_reg_bridge.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared types and constants for the I2C register-bridge target.
//   state_t  - protocol FSM state encoding
//   ACK/NACK - SDA level of the acknowledge bit
//   RW_READ  - value of the R/W bit that selects a read
//   CNT_W    - width of the in-byte bit counter
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_DEV_ACK,
    S_SUB_HI,
    S_SUB_HI_ACK,
    S_SUB_LO,
    S_SUB_LO_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_MACK,
    S_IGNORE
  } state_t;

  localparam logic ACK     = 1'b0;
  localparam logic NACK    = 1'b1;
  localparam logic RW_READ = 1'b1;
  localparam int   CNT_W   = 4;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: conditions one raw I2C pin.
//   2-FF synchronizer -> FILT_LEN-deep majority-free glitch filter -> edge detect.
// Ports:
//   CLK_50   in  system clock
//   RESET    in  synchronous active-high reset
//   i_raw    in  raw pin value
//   o_level  out filtered level
//   o_rise   out one-cycle pulse on a filtered 0->1
//   o_fall   out one-cycle pulse on a filtered 1->0
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic CLK_50,
  input  logic RESET,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic                r_s1;
  logic                r_s2;
  logic [FILT_LEN-1:0] r_hist;
  logic                r_level;
  logic                r_level_d;

  // Idle I2C lines are high, so everything resets to 1 to avoid a
  // spurious edge when reset is released on a quiet bus.
  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_hist    <= '1;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
    end else begin
      r_s1      <= i_raw;
      r_s2      <= r_s1;
      r_hist    <= {r_hist[FILT_LEN-2:0], r_s2};
      // The level only moves once FILT_LEN samples agree; otherwise it holds.
      if (&r_hist) begin
        r_level <= 1'b1;
      end else if (~|r_hist) begin
        r_level <= 1'b0;
      end
      r_level_d <= r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_d;
  assign o_fall  = ~r_level & r_level_d;

endmodule

// File: rtl/i2c_slave_reg_bridge.sv
// i2c_slave_reg_bridge: I2C target with 16-bit auto-incrementing sub-address
// and 8-bit data, bridged onto a single-cycle register bus.
// Ports:
//   CLK_50      in   system clock
//   RESET       in   synchronous active-high reset
//   I2C_SCL     in   raw SCL pin
//   I2C_SDA_IN  in   raw SDA pin
//   I2C_SDA_OE  out  1 = pull SDA low
//   REG_ADDR    out  current sub-address
//   REG_WDATA   out  write data
//   REG_WE      out  one-cycle write strobe
//   REG_RE      out  one-cycle read request
//   REG_RDATA   in   read data, valid the cycle after REG_RE
//   BUSY        out  addressed transfer in progress
//   DBG_STATE   out  protocol FSM state, for observation
// Register bus handshake: REG_WE/REG_RE are single-cycle strobes qualified by
// REG_ADDR (and REG_WDATA for writes); there is no back-pressure, and the
// register side must present REG_RDATA exactly one cycle after REG_RE.
module i2c_slave_reg_bridge
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int         FILT_LEN = 3,
  parameter int         HOLD_CYC = 4
) (
  input  logic        CLK_50,
  input  logic        RESET,
  input  logic        I2C_SCL,
  input  logic        I2C_SDA_IN,
  output logic        I2C_SDA_OE,
  output logic [15:0] REG_ADDR,
  output logic [7:0]  REG_WDATA,
  output logic        REG_WE,
  output logic        REG_RE,
  input  logic [7:0]  REG_RDATA,
  output logic        BUSY,
  output state_t      DBG_STATE
);

  localparam int HCW = $clog2(HOLD_CYC + 1);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .CLK_50  (CLK_50),
    .RESET   (RESET),
    .i_raw   (I2C_SCL),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .CLK_50  (CLK_50),
    .RESET   (RESET),
    .i_raw   (I2C_SDA_IN),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  state_t           r_state, w_next;
  logic [7:0]       r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_rw;
  logic [7:0]       r_sub_hi;
  logic [15:0]      r_addr;
  logic [7:0]       r_wdata;
  logic             r_we, r_re, r_re_dly, r_load;
  logic             r_sda_oe, r_busy;
  logic [HCW-1:0]   r_hold_cnt;
  logic             r_hold_act;

  logic       w_start, w_stop, w_last, w_oe_target;
  logic [7:0] w_byte;

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;
  assign w_byte  = {r_shift[6:0], w_sda};
  assign w_last  = (r_bit_cnt == CNT_W'(7));

  // Next state: START/STOP win over any bit processing in the same cycle.
  always_comb begin
    w_next = r_state;
    if (w_start) begin
      w_next = S_DEV_ADDR;
    end else if (w_stop) begin
      w_next = S_IDLE;
    end else if (w_scl_rise) begin
      case (r_state)
        S_DEV_ADDR:   if (w_last) w_next = (w_byte[7:1] == DEV_ADDR) ? S_DEV_ACK : S_IGNORE;
        S_DEV_ACK:    w_next = (r_rw == RW_READ) ? S_RD_DATA : S_SUB_HI;
        S_SUB_HI:     if (w_last) w_next = S_SUB_HI_ACK;
        S_SUB_HI_ACK: w_next = S_SUB_LO;
        S_SUB_LO:     if (w_last) w_next = S_SUB_LO_ACK;
        S_SUB_LO_ACK: w_next = S_WR_DATA;
        S_WR_DATA:    if (w_last) w_next = S_WR_ACK;
        S_WR_ACK:     w_next = S_WR_DATA;
        S_RD_DATA:    if (w_last) w_next = S_RD_MACK;
        S_RD_MACK:    w_next = (w_sda == ACK) ? S_RD_DATA : S_IGNORE;
        default:      w_next = r_state;
      endcase
    end
  end

  // SDA drive applied at each hold point; since the state has already
  // advanced on the preceding SCL rise, it is a pure function of state.
  always_comb begin
    w_oe_target = 1'b0;
    case (r_state)
      S_DEV_ACK, S_SUB_HI_ACK, S_SUB_LO_ACK, S_WR_ACK: w_oe_target = ~ACK;
      S_RD_DATA:                                       w_oe_target = ~r_shift[7];
      default:                                         w_oe_target = 1'b0;
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_IDLE) begin
        r_busy <= 1'b0;
      end else if (w_next == S_DEV_ACK) begin
        r_busy <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_rw       <= 1'b0;
      r_sub_hi   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_re_dly   <= 1'b0;
      r_load     <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_hold_cnt <= '0;
      r_hold_act <= 1'b0;
    end else begin
      r_we     <= 1'b0;
      r_re     <= r_re_dly;
      r_re_dly <= 1'b0;
      r_load   <= r_re;
      if (r_load) r_shift <= REG_RDATA;
      if (r_we)   r_addr  <= r_addr + 16'd1;

      // Hold timer: SDA_OE is only allowed to change HOLD_CYC cycles
      // after a filtered SCL fall.
      if (w_scl_fall) begin
        r_hold_cnt <= HCW'(1);
        r_hold_act <= 1'b1;
      end else if (r_hold_act) begin
        if (r_hold_cnt == HCW'(HOLD_CYC)) begin
          r_sda_oe   <= w_oe_target;
          r_hold_act <= 1'b0;
        end else begin
          r_hold_cnt <= r_hold_cnt + HCW'(1);
        end
      end

      if (w_start || w_stop) begin
        r_bit_cnt  <= '0;
        r_sda_oe   <= 1'b0;
        r_hold_act <= 1'b0;
      end else if (w_scl_rise) begin
        case (r_state)
          S_DEV_ADDR, S_SUB_HI, S_SUB_LO, S_WR_DATA: begin
            r_shift   <= w_byte;
            r_bit_cnt <= w_last ? '0 : r_bit_cnt + CNT_W'(1);
            if (w_last) begin
              case (r_state)
                S_DEV_ADDR: r_rw     <= w_byte[0];
                S_SUB_HI:   r_sub_hi <= w_byte;
                S_SUB_LO:   r_addr   <= {r_sub_hi, w_byte};
                default: begin
                  r_wdata <= w_byte;
                  r_we    <= 1'b1;
                end
              endcase
            end
          end
          S_RD_DATA: begin
            r_shift   <= {r_shift[6:0], 1'b0};
            r_bit_cnt <= w_last ? '0 : r_bit_cnt + CNT_W'(1);
          end
          S_DEV_ACK: begin
            if (r_rw == RW_READ) r_re <= 1'b1;
          end
          S_RD_MACK: begin
            // Increment first; the follow-on read strobe goes out a cycle
            // later so it carries the new address.
            r_addr <= r_addr + 16'd1;
            if (w_sda == ACK) r_re_dly <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign I2C_SDA_OE = r_sda_oe;
  assign REG_ADDR   = r_addr;
  assign REG_WDATA  = r_wdata;
  assign REG_WE     = r_we;
  assign REG_RE     = r_re;
  assign BUSY       = r_busy;
  assign DBG_STATE  = r_state;

endmodule
